// File: rtl/retire_write_scheduler.sv
// Retirement write scheduler: 4-lane compacting enqueue into a small FIFO,
// 3-port oldest-first drain with same-address coalescing inside each drain group.
module retire_write_scheduler #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   in_valid,
  input  logic [79:0]                  in_data,
  output logic                         in_ready,
  input  logic                         hold,
  output logic [2:0]                   wr_en,
  output logic [59:0]                  wr_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [19:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [2:0]    n_in;
  logic [1:0]    slot [4];
  logic [1:0]    n_out;
  logic [19:0]   ent [3];
  logic [2:0]    en_next;

  // A concurrent drain is deliberately not credited toward free space.
  assign in_ready = (count <= CW'(DEPTH - 4));
  assign empty    = (count == '0);

  always_comb begin
    n_in = '0;
    for (int i = 0; i < 4; i++) begin
      slot[i] = n_in[1:0];
      n_in    = n_in + {2'b00, in_valid[i]};
    end
    if (!in_ready) n_in = '0;

    if (hold)                    n_out = 2'd0;
    else if (count >= CW'(3))    n_out = 2'd3;
    else                         n_out = count[1:0];

    for (int k = 0; k < 3; k++) ent[k] = mem[rd_ptr + PW'(k)];

    // An older port is silenced when a younger port in the same group hits its register.
    en_next = '0;
    for (int k = 0; k < 3; k++) begin
      en_next[k] = (2'(k) < n_out);
      for (int j = k + 1; j < 3; j++) begin
        if ((2'(j) < n_out) && (ent[j][3:0] == ent[k][3:0])) en_next[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && in_ready) begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i]) mem[wr_ptr + PW'(slot[i])] <= in_data[20*i +: 20];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      wr_en   <= '0;
      wr_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_in);
      rd_ptr <= rd_ptr + PW'(n_out);
      count  <= count + CW'(n_in) - CW'(n_out);
      wr_en  <= en_next;
      for (int k = 0; k < 3; k++) begin
        if (2'(k) < n_out) wr_data[20*k +: 20] <= ent[k];
      end
    end
  end

endmodule

// File: tb/tb_retire_write_scheduler.sv
// Bench for retire_write_scheduler: directed vector table, a wrap-around stream,
// and random traffic, all checked against a queue-based reference model.
module tb_retire_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [79:0] in_data;
  logic        in_ready;
  logic        hold;
  logic [2:0]  wr_en;
  logic [59:0] wr_data;
  logic [3:0]  count;
  logic        empty;

  always #5 clk = ~clk;

  retire_write_scheduler #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .hold(hold), .wr_en(wr_en), .wr_data(wr_data),
    .count(count), .empty(empty)
  );

  int tests = 0;
  int fails = 0;

  logic [19:0] q[$];
  logic [2:0]  m_en;
  logic [59:0] m_data;
  logic        m_acc;
  logic [15:0] rf [16];
  logic        collect;
  logic [19:0] obs[$];

  typedef struct {
    logic        rst;
    logic        hold;
    logic [3:0]  vin;
    logic [79:0] din;
    logic [3:0]  cnt;
    logic [2:0]  en;
    logic        rdy;
  } vec_t;

  vec_t tbl [20];

  function automatic logic [19:0] ent(input logic [15:0] v, input logic [3:0] a);
    return {v, a};
  endfunction

  function automatic logic [79:0] lanes(input logic [19:0] e0, input logic [19:0] e1,
                                        input logic [19:0] e2, input logic [19:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic vec_t mk(input logic r, input logic h, input logic [3:0] v,
                              input logic [79:0] d, input logic [3:0] c,
                              input logic [2:0] e, input logic y);
    vec_t t;
    t.rst = r; t.hold = h; t.vin = v; t.din = d; t.cnt = c; t.en = e; t.rdy = y;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: FIFO as a queue; each edge pops up to 3 (unless held), then appends accepted lanes.
  task automatic model_step();
    logic [19:0] grp[$];
    int n;
    if (rst) begin
      q.delete();
      m_en   = '0;
      m_data = '0;
      m_acc  = 1'b0;
      return;
    end
    m_acc = ((8 - q.size()) >= 4);
    n = hold ? 0 : ((q.size() < 3) ? q.size() : 3);
    m_en = '0;
    for (int k = 0; k < n; k++) grp.push_back(q.pop_front());
    for (int k = 0; k < n; k++) begin
      m_data[20*k +: 20] = grp[k];
      m_en[k] = 1'b1;
      for (int j = k + 1; j < n; j++)
        if (grp[j][3:0] == grp[k][3:0]) m_en[k] = 1'b0;
    end
    if (m_acc)
      for (int i = 0; i < 4; i++)
        if (in_valid[i]) q.push_back(in_data[20*i +: 20]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("count", 64'(count), 64'(q.size()));
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("in_ready", 64'(in_ready), 64'(q.size() <= 4));
    check("wr_en", 64'(wr_en), 64'(m_en));
    check("wr_data", 64'(wr_data), 64'(m_data));
    for (int p = 0; p < 3; p++) begin
      if (wr_en[p]) begin
        rf[wr_data[20*p +: 4]] = wr_data[20*p+4 +: 16];
        if (collect) obs.push_back(wr_data[20*p +: 20]);
      end
    end
  endtask

  initial begin
    int sent;
    logic [19:0] exp_stream[$];

    for (int i = 0; i < 16; i++) rf[i] = '0;
    collect = 1'b0;
    rst = 1'b1; hold = 1'b0; in_valid = '0; in_data = '0;

    tbl[0]  = mk(1, 0, 4'b0000, '0, 0, 3'b000, 1);
    tbl[1]  = mk(0, 0, 4'b0011, lanes(ent(16'h1111, 1), ent(16'h2222, 2), '0, '0), 2, 3'b000, 1);
    tbl[2]  = mk(0, 0, 4'b0000, '0, 0, 3'b011, 1);
    tbl[3]  = mk(0, 1, 4'b1111, lanes(ent(16'h100, 0), ent(16'h101, 1), ent(16'h102, 2), ent(16'h103, 3)), 4, 3'b000, 1);
    tbl[4]  = mk(0, 1, 4'b1111, lanes(ent(16'h104, 4), ent(16'h105, 5), ent(16'h106, 6), ent(16'h107, 7)), 8, 3'b000, 0);
    tbl[5]  = mk(0, 1, 4'b1111, lanes(ent(16'hDEAD, 5), ent(16'hDEAD, 5), ent(16'hDEAD, 5), ent(16'hDEAD, 5)), 8, 3'b000, 0);
    tbl[6]  = mk(0, 0, 4'b0000, '0, 5, 3'b111, 0);
    tbl[7]  = mk(0, 0, 4'b0000, '0, 2, 3'b111, 1);
    tbl[8]  = mk(0, 0, 4'b0000, '0, 0, 3'b011, 1);
    tbl[9]  = mk(0, 0, 4'b0111, lanes(ent(16'h000A, 5), ent(16'h000B, 5), ent(16'h000C, 6), '0), 3, 3'b000, 1);
    tbl[10] = mk(0, 0, 4'b0000, '0, 0, 3'b110, 1);
    tbl[11] = mk(0, 1, 4'b1111, lanes(ent(16'h208, 8), ent(16'h209, 9), ent(16'h20A, 10), ent(16'h20B, 11)), 4, 3'b000, 1);
    tbl[12] = mk(0, 1, 4'b0001, lanes(ent(16'h20C, 12), '0, '0, '0), 5, 3'b000, 0);
    tbl[13] = mk(0, 0, 4'b0011, lanes(ent(16'h20D, 13), ent(16'h20E, 14), '0, '0), 2, 3'b111, 1);
    tbl[14] = mk(0, 0, 4'b0011, lanes(ent(16'h20D, 13), ent(16'h20E, 14), '0, '0), 2, 3'b011, 1);
    tbl[15] = mk(0, 0, 4'b0000, '0, 0, 3'b011, 1);
    tbl[16] = mk(0, 1, 4'b1111, lanes(ent(16'h308, 8), ent(16'h309, 9), ent(16'h30A, 10), ent(16'h30B, 11)), 4, 3'b000, 1);
    tbl[17] = mk(0, 1, 4'b0011, lanes(ent(16'h30C, 12), ent(16'h30D, 13), '0, '0), 6, 3'b000, 0);
    tbl[18] = mk(1, 0, 4'b1111, lanes(ent(16'h40C, 12), ent(16'h40D, 13), ent(16'h40E, 14), ent(16'h40F, 15)), 0, 3'b000, 1);
    tbl[19] = mk(0, 0, 4'b0000, '0, 0, 3'b000, 1);

    for (int r = 0; r < 20; r++) begin
      rst = tbl[r].rst; hold = tbl[r].hold;
      in_valid = tbl[r].vin; in_data = tbl[r].din;
      cycle();
      check($sformatf("tbl%0d_count", r), 64'(count), 64'(tbl[r].cnt));
      check($sformatf("tbl%0d_wr_en", r), 64'(wr_en), 64'(tbl[r].en));
      check($sformatf("tbl%0d_ready", r), 64'(in_ready), 64'(tbl[r].rdy));
    end
    check("tbl1_port0", 64'(tbl[2].rst), 64'(0));
    check("rf_r5_coalesced", 64'(rf[5]), 64'(16'h000B));

    // Wrap-around stream of single-lane writes with alternating hold.
    collect = 1'b1;
    sent = 0;
    for (int c = 0; c < 200 && sent < 20; c++) begin
      hold = c[0];
      in_valid = 4'b0001;
      in_data = lanes(ent(16'h5000 + 16'(sent), 4'(sent % 16)), '0, '0, '0);
      cycle();
      if (m_acc) begin
        exp_stream.push_back(ent(16'h5000 + 16'(sent), 4'(sent % 16)));
        sent++;
      end
    end
    in_valid = '0; hold = 1'b0;
    for (int c = 0; c < 20 && q.size() != 0; c++) cycle();
    cycle();
    collect = 1'b0;
    check("wrap_sent", 64'(sent), 64'(20));
    check("wrap_obs_len", 64'(obs.size()), 64'(20));
    for (int i = 0; i < 20; i++) begin
      if (i < obs.size() && i < exp_stream.size())
        check($sformatf("wrap_order%0d", i), 64'(obs[i]), 64'(exp_stream[i]));
    end

    // Random traffic with narrow address range to exercise coalescing.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      hold = ($urandom_range(0, 3) == 0);
      in_valid = 4'($urandom);
      for (int i = 0; i < 4; i++)
        in_data[20*i +: 20] = ent(16'($urandom), 4'($urandom_range(0, 3)));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
